// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding, sizing helpers and buffer index mapping for the systolic feeder
package systolic_pkg;

  typedef enum logic [2:0] {LOAD, LOADED, INIT, STREAM, FLUSH, DONE} state_e;

  localparam int DEF_N      = 2;
  localparam int NUM_ELEM   = 2 * DEF_N * DEF_N;
  localparam int STREAM_LEN = 3 * DEF_N - 2;

  function automatic int num_elem(input int n);
    return 2 * n * n;
  endfunction

  function automatic int stream_len(input int n);
    return 3 * n - 2;
  endfunction

  function automatic int a_idx(input int n, input int i, input int k);
    return i * n + k;
  endfunction

  function automatic int b_idx(input int n, input int k, input int j);
    return n * n + k * n + j;
  endfunction

endpackage

// File: rtl/operand_buf.sv
// operand_buf: element register file with one write port and all entries readable in parallel
module operand_buf #(
  parameter int D_W   = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [D_W-1:0]       wdata,
  output logic [DEPTH*D_W-1:0] rdata
);

  logic [D_W-1:0] mem_q [DEPTH];
  logic [D_W-1:0] mem_d [DEPTH];

  // write the addressed entry, all others hold
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++)
      if (we && waddr == AW'(i)) mem_d[i] = wdata;
  end

  // contents are not reset: a full reload always precedes use
  always_ff @(posedge clk)
    mem_q <= mem_d;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rd
    assign rdata[g*D_W +: D_W] = mem_q[g];
  end

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers A and B from a byte-serial load port and streams them diagonally skewed into a systolic MAC array
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int D_W = 8,
  parameter int N   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic [D_W-1:0] load_data,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           init,
  output logic [N*D_W-1:0] x_flat,
  output logic [N*D_W-1:0] y_flat
);

  localparam int N_ELEM = num_elem(N);
  localparam int S_LEN  = stream_len(N);
  localparam int CW     = $clog2(N_ELEM + 1);
  localparam int TW     = $clog2(3 * N - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       t_q, t_d;
  logic                load_ready_q, load_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                init_q, init_d;
  logic [N*D_W-1:0]    x_q, x_d;
  logic [N*D_W-1:0]    y_q, y_d;
  logic [N_ELEM*D_W-1:0] ops;
  logic                xfer;

  assign xfer = load_valid && load_ready_q;

  operand_buf #(.D_W(D_W), .DEPTH(N_ELEM), .AW(CW)) u_buf (
    .clk   (clk),
    .we    (xfer),
    .waddr (cnt_q),
    .wdata (load_data),
    .rdata (ops)
  );

  // next state and counters; DONE already accepts the first element of the next load
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    case (state_q)
      LOAD: if (xfer) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N_ELEM - 1)) state_d = LOADED;
      end
      LOADED: if (start) state_d = INIT;
      INIT: begin
        state_d = STREAM;
        t_d     = '0;
      end
      STREAM: if (t_q == TW'(S_LEN - 1)) state_d = FLUSH;
              else t_d = t_q + 1'b1;
      FLUSH: begin
        state_d = DONE;
        cnt_d   = '0;
      end
      DONE: begin
        state_d = LOAD;
        if (xfer) cnt_d = cnt_q + 1'b1;
      end
      default: state_d = LOAD;
    endcase
  end

  // outputs decoded from the next state so the registered outputs line up with the state register
  always_comb begin
    load_ready_d = state_d == LOAD || state_d == DONE;
    busy_d       = state_d inside {INIT, STREAM, FLUSH};
    done_d       = state_d == DONE;
    init_d       = state_d == INIT;
    x_d          = '0;
    y_d          = '0;
    if (state_d == STREAM)
      for (int r = 0; r < N; r++)
        for (int k = 0; k < N; k++)
          if (int'(t_d) == r + k) begin
            x_d[r*D_W +: D_W] = ops[a_idx(N, r, k)*D_W +: D_W];
            y_d[r*D_W +: D_W] = ops[b_idx(N, k, r)*D_W +: D_W];
          end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q      <= LOAD;
      cnt_q        <= '0;
      t_q          <= '0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      init_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      t_q          <= t_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      init_q       <= init_d;
      x_q          <= x_d;
      y_q          <= y_d;
    end

  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign init       = init_q;
  assign x_flat     = x_q;
  assign y_flat     = y_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard bench for N=2 and N=3 feeders, including an array-result model
module tb_systolic_feeder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        lv  [2];
  logic        st  [2];
  logic [7:0]  ld  [2];
  logic        rdy [2];
  logic        bsy [2];
  logic        dn  [2];
  logic        ini [2];
  logic [15:0] x2, y2;
  logic [23:0] x3, y3;

  systolic_feeder #(.D_W(8), .N(2)) dut2 (
    .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(rdy[0]), .load_data(ld[0]),
    .start(st[0]), .busy(bsy[0]), .done(dn[0]), .init(ini[0]), .x_flat(x2), .y_flat(y2)
  );

  systolic_feeder #(.D_W(8), .N(3)) dut3 (
    .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(rdy[1]), .load_data(ld[1]),
    .start(st[1]), .busy(bsy[1]), .done(dn[1]), .init(ini[1]), .x_flat(x3), .y_flat(y3)
  );

  typedef struct packed {
    logic        init;
    logic        busy;
    logic        done;
    logic        rdy;
    logic [23:0] x;
    logic [23:0] y;
  } obs_t;

  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];

  int m_nom [18] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int m_b2b [18] = '{9, 8, 7, 6, 2, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int m_n3  [18] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 2, 3, 4, 5, 6, 7, 8, 9};

  function automatic obs_t observe(input int s);
    return s == 1 ? {ini[1], bsy[1], dn[1], rdy[1], x3, y3}
                  : {ini[0], bsy[0], dn[0], rdy[0], 8'h00, x2, 8'h00, y2};
  endfunction

  function automatic obs_t reset_obs();
    obs_t e;
    e     = '0;
    e.rdy = 1'b1;
    return e;
  endfunction

  // cycle c after the start edge: 1=INIT, 2..3n-1 stream t=c-2, 3n=FLUSH, 3n+1=DONE
  function automatic obs_t expect_at(input int n, input int v[18], input int c);
    obs_t e;
    int   t, k;
    e = '0;
    if (c == 1) begin
      e.init = 1'b1;
      e.busy = 1'b1;
    end else if (c <= 3 * n - 1) begin
      e.busy = 1'b1;
      t = c - 2;
      for (int r = 0; r < n; r++) begin
        k = t - r;
        if (k >= 0 && k < n) begin
          e.x[r*8 +: 8] = 8'(v[r * n + k]);
          e.y[r*8 +: 8] = 8'(v[n * n + k * n + r]);
        end
      end
    end else if (c == 3 * n) begin
      e.busy = 1'b1;
    end else begin
      e.done = 1'b1;
      e.rdy  = 1'b1;
    end
    return e;
  endfunction

  task automatic load_mat(input int s, input int n, input int v[18], input bit gaps, input bit start_last);
    for (int i = 0; i < 2 * n * n; i++) begin
      int w;
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        lv[s] = 1'b0;
      end
      @(negedge clk);
      lv[s] = 1'b1;
      ld[s] = 8'(v[i]);
      st[s] = start_last && i == 2 * n * n - 1;
      w = 0;
      while (!rdy[s] && w < 20) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (w == 20) begin
        errors++;
        $display("FAIL load_timeout inst=%0d idx=%0d got ready=%b required 1", s, i, rdy[s]);
      end
    end
    @(negedge clk);
    lv[s] = 1'b0;
    st[s] = 1'b0;
    checks++;
    if (rdy[s] !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_load inst=%0d got %b required 0", s, rdy[s]);
    end
  endtask

  task automatic run(input int s, input int n, input int v[18], input int restart_at, input string tag);
    obs_t o, e;
    int   cx [16][3];
    int   cy [16][3];
    int   z, ez, w;
    for (int u = 0; u < 16; u++)
      for (int r = 0; r < 3; r++) begin
        cx[u][r] = 0;
        cy[u][r] = 0;
      end
    for (int c = 1; c <= 3 * n + 1; c++) sb.push_back(expect_at(n, v, c));
    @(negedge clk);
    st[s] = 1'b1;
    for (int c = 1; c <= 3 * n + 1; c++) begin
      @(negedge clk);
      o = observe(s);
      st[s] = c == restart_at;
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle=k+%0d got init=%b busy=%b done=%b rdy=%b x=%h y=%h required init=%b busy=%b done=%b rdy=%b x=%h y=%h",
                 tag, c, o.init, o.busy, o.done, o.rdy, o.x, o.y, e.init, e.busy, e.done, e.rdy, e.x, e.y);
      end
      for (int r = 0; r < n; r++) begin
        cx[c][r] = int'(o.x[r*8 +: 8]);
        cy[c][r] = int'(o.y[r*8 +: 8]);
      end
    end
    st[s] = 1'b0;
    @(negedge clk);
    o = observe(s);
    checks++;
    if (o !== reset_obs()) begin
      errors++;
      $display("FAIL %s after_done got init=%b busy=%b done=%b rdy=%b x=%h y=%h required idle with rdy=1",
               tag, o.init, o.busy, o.done, o.rdy, o.x, o.y);
    end
    // PE(i,j) multiplies row i delayed j cycles with column j delayed i cycles
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        z  = 0;
        ez = 0;
        for (int u = 0; u < 16; u++) begin
          w = u + j - i;
          if (w >= 0 && w < 16) z += cx[u][i] * cy[w][j];
        end
        for (int k = 0; k < n; k++) ez += v[i * n + k] * v[n * n + k * n + j];
        checks++;
        if (z !== ez) begin
          errors++;
          $display("FAIL %s z[%0d][%0d] got %0d required %0d", tag, i, j, z, ez);
        end
      end
  endtask

  task automatic check_idle(input int s, input int cycles, input string tag);
    repeat (cycles) begin
      @(negedge clk);
      checks++;
      if (ini[s] !== 1'b0 || bsy[s] !== 1'b0) begin
        errors++;
        $display("FAIL %s got init=%b busy=%b required init=0 busy=0", tag, ini[s], bsy[s]);
      end
    end
  endtask

  task automatic test_reset();
    obs_t o;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = observe(s);
      checks++;
      if (o !== reset_obs()) begin
        errors++;
        $display("FAIL reset_values inst=%0d got %h required %h", s, o, reset_obs());
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_nominal();
    load_mat(0, 2, m_nom, 1'b0, 1'b0);
    run(0, 2, m_nom, -1, "nominal");
  endtask

  task automatic test_reset_mid_stream();
    obs_t o;
    load_mat(0, 2, m_nom, 1'b0, 1'b0);
    @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    o = observe(0);
    checks++;
    if (o !== reset_obs()) begin
      errors++;
      $display("FAIL reset_mid_stream got %h required %h", o, reset_obs());
    end
    @(negedge clk);
    rst   = 1'b1;
    st[0] = 1'b1;
    check_idle(0, 3, "start_after_reset");
    st[0] = 1'b0;
    load_mat(0, 2, m_nom, 1'b0, 1'b0);
    run(0, 2, m_nom, -1, "reload_after_reset");
  endtask

  task automatic test_backpressure();
    load_mat(0, 2, m_nom, 1'b1, 1'b0);
    lv[0] = 1'b1;
    ld[0] = 8'hff;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rdy[0] !== 1'b0) begin
        errors++;
        $display("FAIL extra_valid_ready got %b required 0", rdy[0]);
      end
    end
    lv[0] = 1'b0;
    run(0, 2, m_nom, -1, "backpressure");
  endtask

  task automatic test_start_edges();
    load_mat(0, 2, m_nom, 1'b0, 1'b1);
    check_idle(0, 4, "start_with_last_transfer");
    run(0, 2, m_nom, 3, "restart_in_stream");
  endtask

  task automatic test_n3();
    load_mat(1, 3, m_n3, 1'b1, 1'b0);
    run(1, 3, m_n3, -1, "n3");
  endtask

  task automatic test_back_to_back();
    load_mat(0, 2, m_nom, 1'b0, 1'b0);
    run(0, 2, m_nom, -1, "b2b_first");
    load_mat(0, 2, m_b2b, 1'b0, 1'b0);
    run(0, 2, m_b2b, -1, "b2b_second");
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      lv[s] = 1'b0;
      st[s] = 1'b0;
      ld[s] = 8'h00;
    end
    test_reset();
    test_nominal();
    test_reset_mid_stream();
    test_backpressure();
    test_start_edges();
    test_n3();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1);
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Operand transmitter for the systolic MAC array. It accepts matrices A and B (N×N, D_W-bit elements) over a byte-serial valid/ready load port and buffers them. On start it drives the array's packed row/column inputs with the standard diagonal skew, preceded by a one-cycle init pulse. It signals done once the last operand has propagated, so that z_flat is valid for C = A·B.

Parameters:
D_W, 8, operand element width in bits; also the load_data width.
N, 2, array dimension; the block buffers 2·N·N elements.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous, active-low reset.
load_valid  input  1  load_data is presented this cycle.
load_ready  output  1  block accepts load_data this cycle.
load_data  input  D_W  element stream: A row-major first, then B row-major.
start  input  1  begin streaming; honoured only in LOADED.
busy  output  1  high in INIT, STREAM and FLUSH.
done  output  1  one-cycle pulse when results are valid.
init  output  1  drives the array's init input.
x_flat  output  N·D_W  row operands; row r occupies bits [(r+1)·D_W-1 -: D_W].
y_flat  output  N·D_W  column operands; column c occupies bits [(c+1)·D_W-1 -: D_W].

Behaviour:
- All outputs are registered.
- Reset values: load_ready=1 (as soon as rst deasserts), busy=0, done=0, init=0, x_flat=0, y_flat=0. State resets to LOAD, load count to 0. Buffer contents are don't-care.
- Reset mid-operation aborts immediately. Outputs return to the reset values, and a full reload is required.
- LOAD state:
  - A transfer occurs when load_valid && load_ready. The element is written to buffer[cnt], and cnt increments.
  - Indices 0..N·N-1 map to A[i][k] with index i·N+k. Indices N·N..2N·N-1 map to B[k][j] with index N·N+k·N+j.
  - When the transfer at cnt = 2N·N-1 occurs, the next state is LOADED and load_ready drops.
  - start in LOAD is ignored, including in the same cycle as the final transfer.
- LOADED state: load_ready=0. start=1 moves to INIT; otherwise the block holds.
- INIT state (1 cycle): init=1, x_flat=y_flat=0, busy=1.
- STREAM state:
  - Runs for STREAM_LEN = 3N-2 cycles, with stream index t = 0..3N-3.
  - Row r slot = A[r][t-r] when 0 ≤ t-r < N, otherwise 0.
  - Column c slot = B[t-c][c] when 0 ≤ t-c < N, otherwise 0.
- FLUSH state (1 cycle): x_flat=y_flat=0, busy=1. This covers the MAC register latency.
- DONE state (1 cycle): done=1, busy=0. The block then returns to LOAD with cnt=0 and load_ready=1.
- Streaming timing: if start is sampled at edge k, init is high in cycle k+1, t=0 is in cycle k+2, FLUSH is in cycle k+3N, and done is in cycle k+3N+1.
- Total latency from start to done is 3N+1 cycles. For N=2 that is 7.
- load_valid outside LOAD is ignored (load_ready=0). No data is lost, because the sender must hold its data.
- start outside LOADED is ignored.
- init is never asserted except in INIT.
- Counters: cnt is sized clog2(2N·N+1) and t is sized clog2(3N-1). Neither counter wraps: both saturate into the state transition.

Decomposition:
- Shared package (systolic_pkg) holds:
  - the state enum {LOAD, LOADED, INIT, STREAM, FLUSH, DONE};
  - the localparams NUM_ELEM = 2·N·N and STREAM_LEN = 3N-2;
  - the element index helper functions.
- One sub-module, operand_buf: an NUM_ELEM×D_W register file with a write port (we, waddr, wdata) and combinational read of all entries. The skew mux and FSM stay in systolic_feeder.

Test Plan:
1. Reset behaviour: assert rst=0 mid-STREAM → next cycle busy=0, init=0, x_flat=0, y_flat=0, load_ready=1. After release, start is ignored until 8 new elements are loaded.
2. N=2 nominal run: load 1,2,3,4,5,6,7,8 (A=[[1,2],[3,4]], B=[[5,6],[7,8]]), then pulse start at edge k. Required response:
   - init=1 at k+1;
   - (x_flat, y_flat) = (0001, 0005) at k+2, (0302, 0607) at k+3, (0400, 0800) at k+4, (0000, 0000) at k+5;
   - FLUSH with zeros at k+6;
   - done=1 for one cycle at k+7;
   - when connected to the array, z = [[19,22],[43,50]].
3. Backpressure and gaps: randomly deassert load_valid during load → 8 transfers still counted exactly. load_ready=0 after the 8th transfer; extra load_valid pulses do not alter the buffer (rerun reproduces the scenario 2 streams).
4. Start edge cases:
   - start together with the 8th transfer → ignored; no init.
   - start asserted again during STREAM → no restart, and done is still at k+7.
5. N=3 parameterisation: load A=I, B=[[1..9]] → STREAM lasts 7 cycles. Row 2's first nonzero is at t=2 and column 2's last nonzero at t=4. done arrives 10 cycles after start, and the array result equals B.
6. Back-to-back runs: after done, load_ready=1 in the same cycle. Reload a new matrix and start → second stream is correct, and no residual data from the first run appears on x_flat or y_flat.
